// File: rtl/tomasulo_pkg.sv
// Shared opcode encodings and decode helpers for the Tomasulo core.
package tomasulo_pkg;

    localparam int FUNC_W = 4;

    typedef logic [FUNC_W-1:0] func_t;

    typedef enum logic [FUNC_W-1:0] {
        OP_ADD   = 4'b0000,
        OP_SUB   = 4'b0001,
        OP_MUL   = 4'b0010,
        OP_DIV   = 4'b0011,
        OP_LOAD  = 4'b0100,
        OP_STORE = 4'b0101,
        OP_BEQ   = 4'b0110,
        OP_BNEQ  = 4'b0111
    } op_e;

    function automatic logic is_branch(input func_t func);
        return (func == OP_BEQ) || (func == OP_BNEQ);
    endfunction

    function automatic logic is_store(input func_t func);
        return func == OP_STORE;
    endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Issue / CDB / lookup / commit bundle between the ROB and the rest of the core.
interface reorder_buffer_if #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 16,
    parameter int REG_W  = 4,
    parameter int FUNC_W = 4
);
    localparam int IDX_W = $clog2(DEPTH);

    logic              alloc_valid;
    logic [FUNC_W-1:0] alloc_func;
    logic [REG_W-1:0]  alloc_rd;
    logic              alloc_ready;
    logic [IDX_W-1:0]  alloc_tag;

    logic              wb_valid;
    logic [IDX_W-1:0]  wb_tag;
    logic [DATA_W-1:0] wb_data;
    logic              wb_mispred;

    logic [IDX_W-1:0]  q_tag;
    logic              q_ready;
    logic [DATA_W-1:0] q_data;

    logic              commit_valid;
    logic              commit_ready;
    logic [FUNC_W-1:0] commit_func;
    logic [REG_W-1:0]  commit_rd;
    logic [DATA_W-1:0] commit_data;
    logic              flush;
    logic [IDX_W:0]    count;

    modport master (
        output alloc_valid, alloc_func, alloc_rd,
        output wb_valid, wb_tag, wb_data, wb_mispred,
        output q_tag, commit_ready,
        input  alloc_ready, alloc_tag, q_ready, q_data,
        input  commit_valid, commit_func, commit_rd, commit_data, flush, count
    );

    modport slave (
        input  alloc_valid, alloc_func, alloc_rd,
        input  wb_valid, wb_tag, wb_data, wb_mispred,
        input  q_tag, commit_ready,
        output alloc_ready, alloc_tag, q_ready, q_data,
        output commit_valid, commit_func, commit_rd, commit_data, flush, count
    );

endinterface

// File: rtl/reorder_buffer_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the reorder buffer; flush snaps everything to empty.
module rob_ptr_ctrl #(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             alloc_fire,
    input  logic             commit_fire,
    input  logic             flush,
    output logic [IDX_W-1:0] head,
    output logic [IDX_W-1:0] tail,
    output logic [IDX_W:0]   count,
    output logic             full,
    output logic             empty
);

    logic [IDX_W-1:0] head_reg, tail_reg;
    logic [IDX_W:0]   count_reg, count_next;

    always_comb begin
        count_next = count_reg;
        unique case ({alloc_fire, commit_fire})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk1) begin
        if (!rst_n || flush) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            if (alloc_fire)  tail_reg <= tail_reg + 1'b1;
            if (commit_fire) head_reg <= head_reg + 1'b1;
            count_reg <= count_next;
        end
    end

    assign head  = head_reg;
    assign tail  = tail_reg;
    assign count = count_reg;
    assign full  = (count_reg == (IDX_W+1)'(DEPTH));
    assign empty = (count_reg == '0);

endmodule

// File: rtl/reorder_buffer.sv
// In-order-commit reorder buffer: allocates at tail, completes from the CDB, commits at head.
module reorder_buffer
    import tomasulo_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 16,
    parameter int REG_W  = 4,
    parameter int FUNC_W = 4
) (
    input  logic             clk1,
    input  logic             rst_n,
    reorder_buffer_if.slave  rob
);

    localparam int IDX_W = $clog2(DEPTH);

    logic              busy_reg    [DEPTH];
    logic              done_reg    [DEPTH];
    logic              mispred_reg [DEPTH];
    logic [FUNC_W-1:0] func_mem    [DEPTH];
    logic [REG_W-1:0]  rd_mem      [DEPTH];
    logic [DATA_W-1:0] data_mem    [DEPTH];

    logic [IDX_W-1:0] head, tail;
    logic [IDX_W:0]   count;
    logic             full, empty;
    logic             alloc_fire, commit_fire, flush;
    logic             commit_valid, q_fwd;
    func_t            head_op;

    rob_ptr_ctrl #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_ptr_ctrl (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .alloc_fire  (alloc_fire),
        .commit_fire (commit_fire),
        .flush       (flush),
        .head        (head),
        .tail        (tail),
        .count       (count),
        .full        (full),
        .empty       (empty)
    );

    assign head_op      = func_t'(func_mem[head]);
    assign commit_valid = !empty && busy_reg[head] && done_reg[head];
    assign commit_fire  = commit_valid && rob.commit_ready;
    assign flush        = commit_fire && is_branch(head_op) && mispred_reg[head];
    // No full bypass: a commit this cycle does not free a slot for this cycle's alloc.
    assign alloc_fire   = rob.alloc_valid && rob.alloc_ready;

    assign rob.alloc_ready  = !full && !flush;
    assign rob.alloc_tag    = tail;
    assign rob.commit_valid = commit_valid;
    assign rob.commit_func  = func_mem[head];
    assign rob.commit_rd    = rd_mem[head];
    assign rob.commit_data  = data_mem[head];
    assign rob.flush        = flush;
    assign rob.count        = count;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic alloc_hit, commit_hit, wb_hit;

            assign alloc_hit  = alloc_fire && (tail == IDX_W'(gi));
            assign commit_hit = commit_fire && (head == IDX_W'(gi));
            assign wb_hit     = rob.wb_valid && (rob.wb_tag == IDX_W'(gi)) && busy_reg[gi]
                                && rst_n && !flush;

            always_ff @(posedge clk1) begin
                if (!rst_n || flush) begin
                    busy_reg[gi]    <= 1'b0;
                    done_reg[gi]    <= 1'b0;
                    mispred_reg[gi] <= 1'b0;
                end else if (alloc_hit) begin
                    busy_reg[gi]    <= 1'b1;
                    done_reg[gi]    <= 1'b0;
                    mispred_reg[gi] <= 1'b0;
                end else begin
                    if (commit_hit) busy_reg[gi] <= 1'b0;
                    if (wb_hit) begin
                        done_reg[gi]    <= 1'b1;
                        mispred_reg[gi] <= rob.wb_mispred;
                    end
                end
            end

            always_ff @(posedge clk1) begin
                if (alloc_hit) begin
                    func_mem[gi] <= rob.alloc_func;
                    rd_mem[gi]   <= rob.alloc_rd;
                end
                if (wb_hit) data_mem[gi] <= rob.wb_data;
            end
        end
    endgenerate

    // CDB forward lets issue see a result in the same cycle it is broadcast.
    assign q_fwd       = rob.wb_valid && (rob.wb_tag == rob.q_tag) && busy_reg[rob.q_tag];
    assign rob.q_ready = q_fwd || (busy_reg[rob.q_tag] && done_reg[rob.q_tag]);
    assign rob.q_data  = q_fwd ? rob.wb_data : data_mem[rob.q_tag];

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed checks of allocation, in-order commit, wrap, flush, lookup forwarding and reset.
module tb_reorder_buffer;
    import tomasulo_pkg::*;

    logic clk1;
    logic rst_n;
    int   n_cmp = 0;
    int   n_bad = 0;

    reorder_buffer_if rob_if ();

    reorder_buffer dut (
        .clk1  (clk1),
        .rst_n (rst_n),
        .rob   (rob_if.slave)
    );

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        rob_if.alloc_valid  = 1'b0;
        rob_if.alloc_func   = '0;
        rob_if.alloc_rd     = '0;
        rob_if.wb_valid     = 1'b0;
        rob_if.wb_tag       = '0;
        rob_if.wb_data      = '0;
        rob_if.wb_mispred   = 1'b0;
        rob_if.q_tag        = '0;
        rob_if.commit_ready = 1'b0;
    endtask

    task automatic alloc_one(input logic [3:0] f, input logic [3:0] r, input int exp_tag);
        rob_if.alloc_valid = 1'b1;
        rob_if.alloc_func  = f;
        rob_if.alloc_rd    = r;
        settle();
        check_val("alloc_ready", 32'(rob_if.alloc_ready), 32'd1);
        check_val("alloc_tag", 32'(rob_if.alloc_tag), 32'(exp_tag));
        tick();
        rob_if.alloc_valid = 1'b0;
    endtask

    task automatic wb_one(input int t, input logic [15:0] d, input logic m);
        rob_if.wb_valid   = 1'b1;
        rob_if.wb_tag     = 3'(t);
        rob_if.wb_data    = d;
        rob_if.wb_mispred = m;
        tick();
        rob_if.wb_valid   = 1'b0;
        rob_if.wb_mispred = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_rd [4];
        exp_rd[0] = 4'd8; exp_rd[1] = 4'd1; exp_rd[2] = 4'd2; exp_rd[3] = 4'd0;

        // Reset state
        idle();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        settle();
        check_val("rst_alloc_ready", 32'(rob_if.alloc_ready), 32'd1);
        check_val("rst_commit_valid", 32'(rob_if.commit_valid), 32'd0);
        check_val("rst_flush", 32'(rob_if.flush), 32'd0);
        check_val("rst_q_ready", 32'(rob_if.q_ready), 32'd0);
        check_val("rst_count", 32'(rob_if.count), 32'd0);

        // Three adds get tags 0,1,2
        alloc_one(OP_ADD, 4'd1, 0);
        alloc_one(OP_ADD, 4'd2, 1);
        alloc_one(OP_ADD, 4'd3, 2);
        settle();
        check_val("t1_count", 32'(rob_if.count), 32'd3);
        check_val("t1_commit_valid", 32'(rob_if.commit_valid), 32'd0);

        // Out-of-order completion, in-order commit
        wb_one(1, 16'h0011, 1'b0);
        rob_if.wb_valid = 1'b1; rob_if.wb_tag = 3'd0; rob_if.wb_data = 16'h0010;
        settle();
        check_val("t2_no_same_cycle_commit", 32'(rob_if.commit_valid), 32'd0);
        tick();
        rob_if.wb_valid = 1'b0;
        settle();
        check_val("t2_commit_valid0", 32'(rob_if.commit_valid), 32'd1);
        check_val("t2_commit_rd0", 32'(rob_if.commit_rd), 32'd1);
        check_val("t2_commit_data0", 32'(rob_if.commit_data), 32'h10);
        rob_if.commit_ready = 1'b1;
        tick();
        check_val("t2_commit_valid1", 32'(rob_if.commit_valid), 32'd1);
        check_val("t2_commit_rd1", 32'(rob_if.commit_rd), 32'd2);
        check_val("t2_commit_data1", 32'(rob_if.commit_data), 32'h11);
        tick();
        rob_if.commit_ready = 1'b0;
        settle();
        check_val("t2_count", 32'(rob_if.count), 32'd1);
        check_val("t2_commit_valid_idle", 32'(rob_if.commit_valid), 32'd0);

        // Fill to 8; tags wrap 7 -> 0
        for (int i = 0; i < 7; i++) alloc_one(OP_ADD, 4'(10 + i), (3 + i) % 8);
        settle();
        check_val("t3_count_full", 32'(rob_if.count), 32'd8);
        check_val("t3_alloc_ready_full", 32'(rob_if.alloc_ready), 32'd0);
        rob_if.alloc_valid = 1'b1; rob_if.alloc_rd = 4'd15;
        tick();
        rob_if.alloc_valid = 1'b0;
        settle();
        check_val("t3_9th_ignored", 32'(rob_if.count), 32'd8);
        wb_one(2, 16'h0033, 1'b0);
        wb_one(3, 16'h0044, 1'b0);
        rob_if.commit_ready = 1'b1;
        rob_if.alloc_valid  = 1'b1; rob_if.alloc_func = OP_ADD; rob_if.alloc_rd = 4'd9;
        settle();
        check_val("t3_full_commit_alloc_ready", 32'(rob_if.alloc_ready), 32'd0);
        check_val("t3_full_commit_valid", 32'(rob_if.commit_valid), 32'd1);
        check_val("t3_full_commit_rd", 32'(rob_if.commit_rd), 32'd3);
        check_val("t3_full_commit_data", 32'(rob_if.commit_data), 32'h33);
        tick();
        check_val("t3_count_after_full_commit", 32'(rob_if.count), 32'd7);
        check_val("t3_alloc_ready7", 32'(rob_if.alloc_ready), 32'd1);
        check_val("t3_alloc_tag7", 32'(rob_if.alloc_tag), 32'd2);
        check_val("t3_commit_rd7", 32'(rob_if.commit_rd), 32'd10);
        check_val("t3_commit_data7", 32'(rob_if.commit_data), 32'h44);
        tick();
        rob_if.alloc_valid = 1'b0; rob_if.commit_ready = 1'b0;
        settle();
        check_val("t3_count_commit_alloc", 32'(rob_if.count), 32'd7);

        // Reset mid-operation with a committable head and a pending writeback
        wb_one(4, 16'h0066, 1'b0);
        rst_n = 1'b0;
        rob_if.commit_ready = 1'b1;
        rob_if.wb_valid = 1'b1; rob_if.wb_tag = 3'd5; rob_if.wb_data = 16'h0077;
        tick();
        rst_n = 1'b1;
        idle();
        settle();
        check_val("t6_count", 32'(rob_if.count), 32'd0);
        check_val("t6_commit_valid", 32'(rob_if.commit_valid), 32'd0);
        check_val("t6_alloc_ready", 32'(rob_if.alloc_ready), 32'd1);
        rob_if.q_tag = 3'd5;
        settle();
        check_val("t6_q_ready", 32'(rob_if.q_ready), 32'd0);

        // Mispredicted beq at head with 4 younger entries
        alloc_one(OP_BEQ, 4'd2, 0);
        for (int i = 0; i < 4; i++) alloc_one(OP_ADD, 4'(4 + i), 1 + i);
        wb_one(0, 16'h0000, 1'b1);
        wb_one(1, 16'h0055, 1'b0);
        rob_if.commit_ready = 1'b1;
        rob_if.alloc_valid  = 1'b1; rob_if.alloc_func = OP_ADD; rob_if.alloc_rd = 4'd8;
        rob_if.wb_valid = 1'b1; rob_if.wb_tag = 3'd2; rob_if.wb_data = 16'h0099;
        settle();
        check_val("t4_commit_valid", 32'(rob_if.commit_valid), 32'd1);
        check_val("t4_flush", 32'(rob_if.flush), 32'd1);
        check_val("t4_alloc_ready_flush", 32'(rob_if.alloc_ready), 32'd0);
        tick();
        idle();
        settle();
        check_val("t4_flush_gone", 32'(rob_if.flush), 32'd0);
        check_val("t4_count", 32'(rob_if.count), 32'd0);
        check_val("t4_commit_valid_after", 32'(rob_if.commit_valid), 32'd0);
        rob_if.q_tag = 3'd1;
        settle();
        check_val("t4_q1_cleared", 32'(rob_if.q_ready), 32'd0);
        rob_if.q_tag = 3'd2;
        settle();
        check_val("t4_q2_wb_dropped", 32'(rob_if.q_ready), 32'd0);
        alloc_one(OP_ADD, 4'd8, 0);
        settle();
        check_val("t4_count_realloc", 32'(rob_if.count), 32'd1);

        // Lookup forwarding, free-tag writeback, overwrite
        alloc_one(OP_ADD, 4'd1, 1);
        alloc_one(OP_ADD, 4'd2, 2);
        rob_if.q_tag = 3'd2;
        rob_if.wb_valid = 1'b1; rob_if.wb_tag = 3'd2; rob_if.wb_data = 16'hBEEF;
        settle();
        check_val("t5_fwd_ready", 32'(rob_if.q_ready), 32'd1);
        check_val("t5_fwd_data", 32'(rob_if.q_data), 32'hBEEF);
        check_val("t5_commit_valid", 32'(rob_if.commit_valid), 32'd0);
        tick();
        rob_if.wb_valid = 1'b0;
        settle();
        check_val("t5_stored_ready", 32'(rob_if.q_ready), 32'd1);
        check_val("t5_stored_data", 32'(rob_if.q_data), 32'hBEEF);
        rob_if.q_tag = 3'd1;
        settle();
        check_val("t5_q1_not_done", 32'(rob_if.q_ready), 32'd0);
        rob_if.q_tag = 3'd5;
        rob_if.wb_valid = 1'b1; rob_if.wb_tag = 3'd5; rob_if.wb_data = 16'h1234;
        settle();
        check_val("t5_free_tag_no_fwd", 32'(rob_if.q_ready), 32'd0);
        tick();
        rob_if.wb_valid = 1'b0;
        settle();
        check_val("t5_free_tag_no_state", 32'(rob_if.q_ready), 32'd0);
        check_val("t5_count", 32'(rob_if.count), 32'd3);
        wb_one(2, 16'hCAFE, 1'b0);
        rob_if.q_tag = 3'd2;
        settle();
        check_val("t5_overwrite", 32'(rob_if.q_data), 32'hCAFE);

        // Correctly predicted bneq commits without flushing
        alloc_one(OP_BNEQ, 4'd0, 3);
        wb_one(0, 16'h00A0, 1'b0);
        wb_one(1, 16'h00A1, 1'b0);
        wb_one(3, 16'h0000, 1'b0);
        rob_if.commit_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            check_val($sformatf("t7_commit_rd%0d", i), 32'(rob_if.commit_rd), 32'(exp_rd[i]));
            check_val($sformatf("t7_no_flush%0d", i), 32'(rob_if.flush), 32'd0);
            tick();
        end
        rob_if.commit_ready = 1'b0;
        settle();
        check_val("t7_count_empty", 32'(rob_if.count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
